// File: rtl/spi_ram_slave.sv
// SPI mode-0 slave front-end for the byte-wide test RAM store.
// Oversamples SCK/CS_N/MOSI on i_clk and decodes READ (0x03) / WRITE (0x02) bursts.
module spi_ram_slave #(
  parameter int unsigned AW          = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_sck,
  input  logic          i_spi_cs_n,
  input  logic          i_spi_mosi,
  output logic          o_spi_miso,
  output logic          o_spi_miso_oe,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  output logic          o_mem_we_n,
  output logic          o_mem_re,
  input  logic [7:0]    i_mem_rdata,
  output logic          o_busy
);

  localparam int unsigned ABYTES = (AW + 7) / 8;
  localparam int unsigned ABITS  = 8 * ABYTES;
  localparam int unsigned CNT_W  = $clog2(ABITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ABITS-2:0] sr, sr_d;
  logic [ABITS-1:0] sr_sh;
  logic [7:0]       tx, tx_d;
  logic             is_read, is_read_d;
  logic             ld, ld_d;
  logic [AW-1:0]    addr_d;
  logic [7:0]       wdata_d;
  logic             we_n_d, re_d, miso_d, oe_d, busy_d;

  // Input synchronisers plus one extra sample of SCK/CS_N for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign sr_sh    = {sr, mosi_s};

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    sr_d      = sr;
    tx_d      = tx;
    is_read_d = is_read;
    ld_d      = o_mem_re;
    addr_d    = o_mem_addr;
    wdata_d   = o_mem_wdata;
    we_n_d    = 1'b1;
    re_d      = 1'b0;

    // Post-write increment happens after the strobe cycle, even across deselect
    if (!o_mem_we_n) addr_d = o_mem_addr + AW'(1);
    if (ld) tx_d = i_mem_rdata;

    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sr_d  = sr_sh[ABITS-2:0];
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt_d = '0;
              if (sr_sh[7:0] == CMD_WRITE) begin
                state_d   = S_ADDR;
                is_read_d = 1'b0;
              end else if (sr_sh[7:0] == CMD_READ) begin
                state_d   = S_ADDR;
                is_read_d = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sr_d  = sr_sh[ABITS-2:0];
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ABITS - 1)) begin
              cnt_d  = '0;
              addr_d = sr_sh[AW-1:0];
              if (is_read) begin
                state_d = S_RDATA;
                re_d    = 1'b1;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (sck_rise) begin
            sr_d  = sr_sh[ABITS-2:0];
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt_d   = '0;
              wdata_d = sr_sh[7:0];
              we_n_d  = 1'b0;
            end
          end
        end
        S_RDATA: begin
          if (sck_rise) begin
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt_d  = '0;
              addr_d = o_mem_addr + AW'(1);
              re_d   = 1'b1;
            end
          end else if (sck_fall && (cnt != '0)) begin
            // Falls before the first rise of a byte keep bit 7 on the line
            tx_d = {tx[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end

    miso_d = (state_d == S_RDATA) ? tx_d[7] : 1'b0;
    oe_d   = (state_d == S_RDATA);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sr            <= '0;
      tx            <= '0;
      is_read       <= 1'b0;
      ld            <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_we_n    <= 1'b1;
      o_mem_re      <= 1'b0;
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      sr            <= sr_d;
      tx            <= tx_d;
      is_read       <= is_read_d;
      ld            <= ld_d;
      o_mem_addr    <= addr_d;
      o_mem_wdata   <= wdata_d;
      o_mem_we_n    <= we_n_d;
      o_mem_re      <= re_d;
      o_spi_miso    <= miso_d;
      o_spi_miso_oe <= oe_d;
      o_busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed bench for spi_ram_slave: acts as SPI master and models the byte store.
module tb_spi_ram_slave;

  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        oe;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we_n;
  logic        re;
  logic [7:0]  rdata;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  logic [15:0] re_addr [0:63];
  int          wr_n, re_n, oe_n, both_n;
  int          n_vec, n_err;

  spi_ram_slave #(.AW(16), .SYNC_STAGES(SYNC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_spi_sck     (sck),
    .i_spi_cs_n    (cs_n),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso),
    .o_spi_miso_oe (oe),
    .o_mem_addr    (addr),
    .o_mem_wdata   (wdata),
    .o_mem_we_n    (we_n),
    .o_mem_re      (re),
    .i_mem_rdata   (rdata),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store model with strobe logging
  always @(posedge clk) begin
    if (rst_n) begin
      if (!we_n) begin
        mem[addr] = wdata;
        wr_addr[wr_n] = addr;
        wr_data[wr_n] = wdata;
        wr_n = wr_n + 1;
      end
      if (re) begin
        rdata <= mem[addr];
        re_addr[re_n] = addr;
        re_n = re_n + 1;
      end
      if (!we_n && re) both_n = both_n + 1;
      if (oe) oe_n = oe_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx[i] = miso;
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rx;
    int w0, r0, o0, k;
    wr_n = 0; re_n = 0; oe_n = 0; both_n = 0;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    mem[16'h0013] = 8'h44;

    // Reset values
    tick(3);
    chk("rst_ctl", 32'({miso, oe, we_n, re, busy}), 32'b00100);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // Single write 0x02 / 0x1234 / 0xA5
    w0 = wr_n; o0 = oe_n;
    cs_n = 1'b0; tick(HALF);
    chk("wr_busy", 32'(busy), 32'h1);
    xfer(8'h02, 8, rx); xfer(8'h12, 8, rx); xfer(8'h34, 8, rx);
    chk("wr_no_early_strobe", 32'(wr_n - w0), 32'h0);
    xfer(8'hA5, 8, rx);
    chk("wr_count", 32'(wr_n - w0), 32'h1);
    chk("wr_addr", 32'(wr_addr[w0]), 32'h1234);
    chk("wr_data", 32'(wr_data[w0]), 32'hA5);
    chk("wr_addr_inc", 32'(addr), 32'h1235);
    chk("wr_no_oe", 32'(oe_n - o0), 32'h0);
    cs_n = 1'b1; tick(2 * HALF);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    chk("wr_addr_hold", 32'(addr), 32'h1235);

    // Read 3 bytes from 0x0010
    r0 = re_n;
    cs_n = 1'b0; tick(HALF);
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
    chk("rd_oe", 32'(oe), 32'h1);
    xfer(8'h00, 8, rx); chk("rd_byte0", 32'(rx), 32'h11);
    xfer(8'h00, 8, rx); chk("rd_byte1", 32'(rx), 32'h22);
    xfer(8'h00, 8, rx); chk("rd_byte2", 32'(rx), 32'h33);
    chk("rd_re_count", 32'(re_n - r0), 32'h4);
    chk("rd_re_first", 32'(re_addr[r0]), 32'h0010);
    chk("rd_prefetch", 32'(re_addr[r0 + 3]), 32'h0013);
    chk("rd_addr", 32'(addr), 32'h0013);
    cs_n = 1'b1; tick(2 * HALF);
    chk("rd_deselect", 32'({oe, busy}), 32'h0);

    // Burst write wrapping at 0xFFFF
    w0 = wr_n;
    cs_n = 1'b0; tick(HALF);
    xfer(8'h02, 8, rx); xfer(8'hFF, 8, rx); xfer(8'hFF, 8, rx);
    xfer(8'h5A, 8, rx); xfer(8'hC3, 8, rx);
    cs_n = 1'b1; tick(2 * HALF);
    chk("wrap_count", 32'(wr_n - w0), 32'h2);
    chk("wrap_addr0", 32'(wr_addr[w0]), 32'hFFFF);
    chk("wrap_data0", 32'(wr_data[w0]), 32'h5A);
    chk("wrap_addr1", 32'(wr_addr[w0 + 1]), 32'h0000);
    chk("wrap_data1", 32'(wr_data[w0 + 1]), 32'hC3);
    chk("wrap_addr_final", 32'(addr), 32'h0001);

    // Unknown command is ignored, then a normal read
    w0 = wr_n; r0 = re_n; o0 = oe_n;
    cs_n = 1'b0; tick(HALF);
    xfer(8'h9F, 8, rx); xfer(8'hFF, 8, rx); xfer(8'h03, 8, rx); xfer(8'h00, 8, rx);
    chk("ign_busy", 32'(busy), 32'h1);
    cs_n = 1'b1; tick(2 * HALF);
    chk("ign_no_we", 32'(wr_n - w0), 32'h0);
    chk("ign_no_re", 32'(re_n - r0), 32'h0);
    chk("ign_no_oe", 32'(oe_n - o0), 32'h0);
    cs_n = 1'b0; tick(HALF);
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h11, 8, rx);
    xfer(8'h00, 8, rx); chk("after_ign_read", 32'(rx), 32'h22);
    cs_n = 1'b1; tick(2 * HALF);

    // Partial write byte is discarded
    w0 = wr_n;
    cs_n = 1'b0; tick(HALF);
    xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h40, 8, rx);
    xfer(8'hFF, 5, rx);
    cs_n = 1'b1;
    k = 0;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      if (!busy) begin
        k = j;
        break;
      end
    end
    chk("abort_busy_fell", 32'(k != 0 && k <= SYNC + 2), 32'h1);
    tick(2 * HALF);
    chk("abort_no_write", 32'(wr_n - w0), 32'h0);

    // Reset in the middle of a read data phase
    w0 = wr_n; r0 = re_n;
    cs_n = 1'b0; tick(HALF);
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h00, 3, rx);
    chk("mid_rd_oe", 32'(oe), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({miso, oe, we_n, re, busy}), 32'b00100);
    chk("async_rst_addr", 32'(addr), 32'h0);
    chk("async_rst_wdata", 32'(wdata), 32'h0);
    cs_n = 1'b1; mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("rst_strobes", 32'({wr_n - w0, re_n - r0}), 32'({32'd0, 32'd1}));
    cs_n = 1'b0; tick(HALF);
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h12, 8, rx);
    xfer(8'h00, 8, rx); chk("post_rst_read", 32'(rx), 32'h33);
    cs_n = 1'b1; tick(2 * HALF);

    chk("we_re_exclusive", 32'(both_n), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
